// File: rtl/mp_mul_seq.sv
// ---------------------------------------------------------------------------
// mp_mul_seq -- sequential multi-precision unsigned multiplier.
//
// Computes a * b (N_BITS x N_BITS -> 2*N_BITS) with one LIMB_W x LIMB_W
// multiplier, one multiply-accumulate per cycle, scanning operand limbs in
// schoolbook order (row i = limb of b, column j = limb of a).
//
// Ports:
//   clk      in   1          single clock, posedge
//   rstn     in   1          asynchronous active-low reset
//   start    in   1          operation request
//   mode     in   1          0 = full 2*N_BITS product, 1 = low N_BITS only
//   a        in   N_BITS     multiplicand, latched on an accepted start
//   b        in   N_BITS     multiplier, latched on an accepted start
//   busy     out  1          operation in progress (RUN / ROWEND)
//   done     out  1          one-cycle pulse, product has just been updated
//   product  out  2*N_BITS   registered result, held until the next done
//
// Handshake: start is sampled on every posedge; it is accepted only in IDLE
// or DONE, and ignored (operands untouched) while busy is high. busy rises
// the cycle after acceptance. done is high for exactly one cycle with busy
// low; product is valid from that cycle until the next done. Holding start
// high through DONE chains the next operation with no idle cycle.
// ---------------------------------------------------------------------------
module mp_mul_seq #(
  parameter int N_BITS = 1024,
  parameter int LIMB_W = 32
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic                  mode,
  input  logic [N_BITS-1:0]     a,
  input  logic [N_BITS-1:0]     b,
  output logic                  busy,
  output logic                  done,
  output logic [2*N_BITS-1:0]   product
);

  localparam int L  = N_BITS / LIMB_W;
  localparam int IW = $clog2(L + 1);     // i can reach L after the last ROWEND
  localparam int AW = $clog2(N_BITS);
  localparam int PW = $clog2(2 * N_BITS);
  localparam int CW = 2 * LIMB_W;

  if ((N_BITS % LIMB_W) != 0) begin : g_bad_multiple
    $error("mp_mul_seq: N_BITS must be an integer multiple of LIMB_W");
  end
  if (L < 2) begin : g_too_few_limbs
    $error("mp_mul_seq: N_BITS/LIMB_W must be at least 2");
  end

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_ROWEND = 2'd2,
    S_DONE   = 2'd3
  } state_e;

  state_e                state_q,   state_d;
  logic [N_BITS-1:0]     a_q,       a_d;
  logic [N_BITS-1:0]     b_q,       b_d;
  logic                  mode_q,    mode_d;
  logic [2*N_BITS-1:0]   p_q,       p_d;
  logic [LIMB_W-1:0]     carry_q,   carry_d;
  logic [IW-1:0]         i_q,       i_d;
  logic [IW-1:0]         j_q,       j_d;
  logic [2*N_BITS-1:0]   product_q, product_d;

  // Limb offsets. Out-of-range values only occur outside RUN/ROWEND, where
  // the selected limbs are not used.
  logic [AW-1:0]     a_off, b_off;
  logic [PW-1:0]     pij_off, pil_off;
  logic [LIMB_W-1:0] a_limb, b_limb, p_limb;
  logic [CW-1:0]     t;
  logic              j_last, i_last;

  always_comb begin
    a_off   = AW'(32'(j_q) * LIMB_W);
    b_off   = AW'(32'(i_q) * LIMB_W);
    pij_off = PW'((32'(i_q) + 32'(j_q)) * LIMB_W);
    pil_off = PW'((32'(i_q) + L) * LIMB_W);
    a_limb  = a_q[a_off +: LIMB_W];
    b_limb  = b_q[b_off +: LIMB_W];
    p_limb  = p_q[pij_off +: LIMB_W];
    // (2^W-1)^2 + 2*(2^W-1) = 2^(2W)-1, so the sum always fits in CW bits.
    t       = CW'(a_limb) * CW'(b_limb) + CW'(p_limb) + CW'(carry_q);
    // Low mode truncates row i at column L-1-i so limbs >= L are never touched.
    j_last  = mode_q ? (j_q == (IW'(L - 1) - i_q)) : (j_q == IW'(L - 1));
    i_last  = (i_q == IW'(L - 1));
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    mode_d    = mode_q;
    p_d       = p_q;
    carry_d   = carry_q;
    i_d       = i_q;
    j_d       = j_q;
    product_d = product_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          mode_d  = mode;
          p_d     = '0;
          carry_d = '0;
          i_d     = '0;
          j_d     = '0;
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_RUN: begin
        p_d[pij_off +: LIMB_W] = t[LIMB_W-1:0];
        carry_d                = t[CW-1:LIMB_W];
        if (j_last) begin
          j_d = '0;
          if (mode_q) begin
            // Row carry would land at or above limb L: drop it.
            carry_d = '0;
            if (i_last) state_d = S_DONE;
            else        i_d     = i_q + IW'(1);
          end else begin
            state_d = S_ROWEND;
          end
        end else begin
          j_d = j_q + IW'(1);
        end
      end

      S_ROWEND: begin
        p_d[pil_off +: LIMB_W] = carry_q;
        carry_d = '0;
        j_d     = '0;
        i_d     = i_q + IW'(1);
        state_d = i_last ? S_DONE : S_RUN;
      end

      default: state_d = S_IDLE;
    endcase

    // Capture includes the write made on the same edge that enters DONE.
    if (state_d == S_DONE) begin
      product_d = mode_q ? {{N_BITS{1'b0}}, p_d[N_BITS-1:0]} : p_d;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= S_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      mode_q    <= 1'b0;
      p_q       <= '0;
      carry_q   <= '0;
      i_q       <= '0;
      j_q       <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      mode_q    <= mode_d;
      p_q       <= p_d;
      carry_q   <= carry_d;
      i_q       <= i_d;
      j_q       <= j_d;
      product_q <= product_d;
    end
  end

  assign busy    = (state_q == S_RUN) || (state_q == S_ROWEND);
  assign done    = (state_q == S_DONE);
  assign product = product_q;

endmodule

// File: tb/tb_mp_mul_seq.sv
// ---------------------------------------------------------------------------
// tb_mp_mul_seq -- self-checking bench for mp_mul_seq.
//
// Two instances share clock and reset: u_small (N_BITS=128, L=4) carries the
// directed cases, u_big uses the default N_BITS=1024 (L=32). Expected
// products come from a wide-integer reference multiply and travel through
// a queue from the driving step to the done pulse. Latency is counted in
// posedges with the accepting edge numbered 1.
// ---------------------------------------------------------------------------
module tb_mp_mul_seq;

  logic clk;
  logic rstn;

  // u_small
  logic          s_start, s_mode, s_busy, s_done;
  logic [127:0]  s_a, s_b;
  logic [255:0]  s_prod;

  // u_big
  logic          g_start, g_mode, g_busy, g_done;
  logic [1023:0] g_a, g_b;
  logic [2047:0] g_prod;

  logic [255:0]  exp_q[$];
  logic [2047:0] exp_big_q[$];

  int n_assert;
  int n_fail;

  // scratch for the inline steps
  logic [127:0] av1, bv1, av2, bv2;
  logic [255:0] e1, e2;
  int           edges;
  bit           seen;

  mp_mul_seq #(.N_BITS(128), .LIMB_W(32)) u_small (
    .clk     (clk),
    .rstn    (rstn),
    .start   (s_start),
    .mode    (s_mode),
    .a       (s_a),
    .b       (s_b),
    .busy    (s_busy),
    .done    (s_done),
    .product (s_prod)
  );

  mp_mul_seq u_big (
    .clk     (clk),
    .rstn    (rstn),
    .start   (g_start),
    .mode    (g_mode),
    .a       (g_a),
    .b       (g_b),
    .busy    (g_busy),
    .done    (g_done),
    .product (g_prod)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic logic [1023:0] rnd1024();
    logic [1023:0] r;
    for (int k = 0; k < 32; k++) r[k*32 +: 32] = $urandom();
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One operation on u_small. Operands and mode are scrambled every cycle
  // while busy; with poke set, start is also re-pulsed mid-run.
  task automatic run_small(input string tag, input logic [127:0] av, input logic [127:0] bv,
                           input logic md, input bit poke);
    logic [255:0] full, exp, held;
    int lat, n, busy_cnt;
    bit got;
    lat  = md ? 11 : 21;
    full = {128'b0, av} * {128'b0, bv};
    exp_q.push_back(md ? {128'b0, full[127:0]} : full);
    s_a = av; s_b = bv; s_mode = md; s_start = 1'b1;
    n = 0; busy_cnt = 0; got = 1'b0;
    while (!got && n < lat + 20) begin
      step();
      n++;
      s_start = 1'b0;
      s_a     = rnd128();
      s_b     = rnd128();
      s_mode  = ~md;
      if (poke && n == 5) s_start = 1'b1;
      if (s_busy) busy_cnt++;
      if (s_done) got = 1'b1;
    end
    s_start = 1'b0;
    chk({tag, " done_seen"}, 256'(got), 256'(1));
    chk({tag, " latency"}, 256'(n), 256'(lat));
    chk({tag, " busy_cycles"}, 256'(busy_cnt), 256'(lat - 1));
    chk({tag, " busy_at_done"}, 256'(s_busy), 256'(0));
    exp  = exp_q.pop_front();
    chk({tag, " product"}, s_prod, exp);
    held = s_prod;
    step();
    chk({tag, " done_pulse_len"}, 256'(s_done), 256'(0));
    chk({tag, " idle_after"}, 256'(s_busy), 256'(0));
    chk({tag, " product_held"}, s_prod, held);
  endtask

  task automatic run_big(input string tag, input logic [1023:0] av, input logic [1023:0] bv,
                         input logic md);
    logic [2047:0] full, exp;
    int lat, n;
    bit got;
    lat  = md ? 529 : 1057;
    full = {1024'b0, av} * {1024'b0, bv};
    exp_big_q.push_back(md ? {1024'b0, full[1023:0]} : full);
    g_a = av; g_b = bv; g_mode = md; g_start = 1'b1;
    n = 0; got = 1'b0;
    while (!got && n < lat + 50) begin
      step();
      n++;
      g_start = 1'b0;
      if (g_done) got = 1'b1;
    end
    chk({tag, " done_seen"}, 256'(got), 256'(1));
    chk({tag, " latency"}, 256'(n), 256'(lat));
    chk({tag, " busy_at_done"}, 256'(g_busy), 256'(0));
    exp = exp_big_q.pop_front();
    for (int c = 0; c < 8; c++)
      chk($sformatf("%s product[%0d]", tag, c), g_prod[c*256 +: 256], exp[c*256 +: 256]);
    step();
    chk({tag, " done_pulse_len"}, 256'(g_done), 256'(0));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    n_assert = 0;
    n_fail   = 0;
    rstn     = 1'b0;
    s_start = 1'b0; s_mode = 1'b0; s_a = '0; s_b = '0;
    g_start = 1'b0; g_mode = 1'b0; g_a = '0; g_b = '0;

    repeat (3) step();
    chk("reset s_busy", 256'(s_busy), 256'(0));
    chk("reset s_done", 256'(s_done), 256'(0));
    chk("reset s_prod", s_prod, 256'(0));
    chk("reset g_busy", 256'(g_busy), 256'(0));
    chk("reset g_prod_lo", g_prod[255:0], 256'(0));
    rstn = 1'b1;
    step();

    // smallest non-trivial product
    run_small("one", 128'd1, 128'd1, 1'b0, 1'b0);
    chk("one literal", s_prod, 256'd1);

    // carries ripple through every limb
    av1 = '1;
    run_small("ones_full", av1, av1, 1'b0, 1'b0);
    chk("ones_full literal", s_prod,
        256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_00000000_00000000_00000000_00000001);
    run_small("ones_low", av1, av1, 1'b1, 1'b0);
    chk("ones_low literal", s_prod, 256'd1);

    // start re-pulsed with new operands while busy
    run_small("ignore_start", rnd128(), rnd128(), 1'b0, 1'b1);

    // back-to-back: start held high through DONE
    av1 = rnd128(); bv1 = rnd128(); av2 = rnd128(); bv2 = rnd128();
    e1 = {128'b0, av1} * {128'b0, bv1};
    e2 = {128'b0, av2} * {128'b0, bv2};
    exp_q.push_back(e1);
    exp_q.push_back(e2);
    s_a = av1; s_b = bv1; s_mode = 1'b0; s_start = 1'b1;
    edges = 0; seen = 1'b0;
    while (!seen && edges < 60) begin
      step();
      edges++;
      if (edges == 1) begin s_a = av2; s_b = bv2; end
      if (s_done) seen = 1'b1;
    end
    chk("b2b first done_seen", 256'(seen), 256'(1));
    chk("b2b first latency", 256'(edges), 256'(21));
    chk("b2b first product", s_prod, exp_q.pop_front());
    step();
    s_start = 1'b0;
    chk("b2b busy_next", 256'(s_busy), 256'(1));
    chk("b2b done_next", 256'(s_done), 256'(0));
    chk("b2b product_held", s_prod, e1);
    edges = 1; seen = 1'b0;
    while (!seen && edges < 60) begin
      step();
      edges++;
      if (s_done) seen = 1'b1;
    end
    chk("b2b second done_seen", 256'(seen), 256'(1));
    chk("b2b second latency", 256'(edges), 256'(21));
    chk("b2b second product", s_prod, exp_q.pop_front());
    step();

    // reset in the middle of RUN
    s_a = rnd128(); s_b = rnd128(); s_mode = 1'b0; s_start = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step();
      s_start = 1'b0;
      if (s_done) seen = 1'b1;
    end
    chk("abort busy_before", 256'(s_busy), 256'(1));
    rstn = 1'b0;
    #2;
    chk("abort product_zero", s_prod, 256'(0));
    chk("abort busy_low", 256'(s_busy), 256'(0));
    chk("abort done_low", 256'(s_done), 256'(0));
    step();
    rstn = 1'b1;
    for (int k = 0; k < 25; k++) begin
      step();
      if (s_done) seen = 1'b1;
    end
    chk("abort no_done", 256'(seen), 256'(0));
    run_small("after_abort", 128'hDEADBEEF, 128'h12345678, 1'b0, 1'b0);

    // random operands on the small instance
    for (int k = 0; k < 6; k++) begin
      run_small($sformatf("rnd_full%0d", k), rnd128(), rnd128(), 1'b0, 1'b0);
      run_small($sformatf("rnd_low%0d", k), rnd128(), rnd128(), 1'b1, 1'b0);
    end

    // default-width instance
    run_big("big_ones_full", '1, '1, 1'b0);
    for (int k = 0; k < 2; k++) begin
      run_big($sformatf("big_rnd_full%0d", k), rnd1024(), rnd1024(), 1'b0);
      run_big($sformatf("big_rnd_low%0d", k), rnd1024(), rnd1024(), 1'b1);
    end

    chk("scoreboard empty", 256'(exp_q.size() + exp_big_q.size()), 256'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
